// File: rtl/vga_pkg.sv
// Shared video types and helpers: RGB565 pixel type, colour constants,
// CRC-16/CCITT-FALSE word update and the picture_check state encoding.
package vga_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t BLACK   = '{r: 5'h00, g: 6'h00, b: 5'h00};
  localparam rgb565_t WHITE   = '{r: 5'h1f, g: 6'h3f, b: 5'h1f};
  localparam rgb565_t RED     = '{r: 5'h1f, g: 6'h00, b: 5'h00};
  localparam rgb565_t GREEN   = '{r: 5'h00, g: 6'h3f, b: 5'h00};
  localparam rgb565_t BLUE    = '{r: 5'h00, g: 6'h00, b: 5'h1f};
  localparam rgb565_t YELLOW  = '{r: 5'h1f, g: 6'h3f, b: 5'h00};
  localparam rgb565_t CYAN    = '{r: 5'h00, g: 6'h3f, b: 5'h1f};
  localparam rgb565_t MAGENTA = '{r: 5'h1f, g: 6'h00, b: 5'h1f};

  localparam int MAX_COUNTER_H = 800;
  localparam int MAX_COUNTER_V = 525;

  localparam logic [15:0] Crc16Init = 16'hFFFF;
  localparam logic [15:0] Crc16Poly = 16'h1021;

  typedef enum logic {
    S_SYNC,
    S_FRAME
  } pc_state_e;

  // One whole 16-bit word per call, MSB first, no reflection.
  function automatic logic [15:0] crc16_ccitt_word(input logic [15:0] crc_in,
                                                   input logic [15:0] data);
    logic [15:0] crc;
    crc = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (crc[15] ^ data[i]) begin
        crc = {crc[14:0], 1'b0} ^ Crc16Poly;
      end else begin
        crc = {crc[14:0], 1'b0};
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/picture_line_meter.sv
// Per-frame line geometry: pixels per line, first-line reference width,
// line count, line-length mismatch flag and counter saturation flag.
module picture_line_meter #(
  parameter int CounterWidthX = 10,
  parameter int CounterWidthY = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear,
  input  logic                     pix_en,
  input  logic                     line_close,
  output logic [CounterWidthX-1:0] width_cur,
  output logic [CounterWidthY-1:0] height_cur,
  output logic                     line_err_cur,
  output logic                     ovf_cur
);

  localparam logic [CounterWidthX-1:0] PixOne  = 1;
  localparam logic [CounterWidthY-1:0] LineOne = 1;
  localparam logic [CounterWidthX-1:0] PixMax  = '1;
  localparam logic [CounterWidthY-1:0] LineMax = '1;

  logic [CounterWidthX-1:0] pix_cnt_reg, pix_cnt_next;
  logic [CounterWidthX-1:0] ref_w_reg, ref_w_next;
  logic [CounterWidthY-1:0] line_cnt_reg, line_cnt_next;
  logic                     line_err_reg, line_err_next;
  logic                     ovf_reg, ovf_next;

  // State after applying this cycle's line close, before any new pixel.
  logic [CounterWidthX-1:0] closed_pix;
  logic [CounterWidthX-1:0] closed_ref;
  logic [CounterWidthY-1:0] closed_lines;
  logic                     closed_err;
  logic                     closed_ovf;

  always_comb begin
    closed_pix   = pix_cnt_reg;
    closed_ref   = ref_w_reg;
    closed_lines = line_cnt_reg;
    closed_err   = line_err_reg;
    closed_ovf   = ovf_reg;
    if (line_close) begin
      if (line_cnt_reg == '0) begin
        closed_ref = pix_cnt_reg;
      end else if (pix_cnt_reg != ref_w_reg) begin
        closed_err = 1'b1;
      end
      if (line_cnt_reg == LineMax) begin
        closed_ovf = 1'b1;
      end else begin
        closed_lines = line_cnt_reg + LineOne;
      end
      closed_pix = '0;
    end
  end

  always_comb begin
    pix_cnt_next  = closed_pix;
    ref_w_next    = closed_ref;
    line_cnt_next = closed_lines;
    line_err_next = closed_err;
    ovf_next      = closed_ovf;
    if (clear) begin
      // A pixel arriving with the frame start seeds the new frame.
      pix_cnt_next  = pix_en ? PixOne : '0;
      ref_w_next    = '0;
      line_cnt_next = '0;
      line_err_next = 1'b0;
      ovf_next      = 1'b0;
    end else if (pix_en) begin
      if (closed_pix == PixMax) begin
        ovf_next = 1'b1;
      end else begin
        pix_cnt_next = closed_pix + PixOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_cnt_reg  <= '0;
      ref_w_reg    <= '0;
      line_cnt_reg <= '0;
      line_err_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      pix_cnt_reg  <= pix_cnt_next;
      ref_w_reg    <= ref_w_next;
      line_cnt_reg <= line_cnt_next;
      line_err_reg <= line_err_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign width_cur    = closed_ref;
  assign height_cur   = closed_lines;
  assign line_err_cur = closed_err;
  assign ovf_cur      = closed_ovf;

endmodule

// File: rtl/picture_check.sv
// Sink-side frame analyser: measures width/height, line consistency and a
// CRC-16 signature per frame. CRC logic is built only with PICTURE_CHECK_CRC_EN.
module picture_check
  import vga_pkg::*;
#(
  parameter int MaxPosCounterX = MAX_COUNTER_H,
  parameter int MaxPosCounterY = MAX_COUNTER_V,
  parameter int CounterWidthX  = $clog2(MaxPosCounterX) + 1,
  parameter int CounterWidthY  = $clog2(MaxPosCounterY) + 1,
  parameter bit VsActiveHigh   = 1'b1,
  parameter int FrameCntWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     vs_i,
  input  logic                     de_i,
  input  rgb565_t                  data_i,
  output logic [CounterWidthX-1:0] width_o,
  output logic [CounterWidthY-1:0] height_o,
  output logic [15:0]              crc_o,
  output logic                     line_err_o,
  output logic                     ovf_err_o,
  output logic                     frame_valid_o,
  output logic [FrameCntWidth-1:0] frame_cnt_o
);

  localparam logic [FrameCntWidth-1:0] FrameOne = 1;

  pc_state_e state_reg, state_next;
  logic      vs_q_reg, de_q_reg;
  logic      vs_act, vs_edge, line_end;
  logic      meter_clear, pix_en, line_close, report;

  logic [CounterWidthX-1:0] meter_width;
  logic [CounterWidthY-1:0] meter_height;
  logic                     meter_line_err, meter_ovf;

  logic [CounterWidthX-1:0] width_reg;
  logic [CounterWidthY-1:0] height_reg;
  logic                     line_err_reg, ovf_err_reg, frame_valid_reg;
  logic [FrameCntWidth-1:0] frame_cnt_reg;

  assign vs_act   = VsActiveHigh ? vs_i : ~vs_i;
  assign vs_edge  = vs_act & ~vs_q_reg;
  assign line_end = de_q_reg & ~de_i;

  always_comb begin
    state_next  = state_reg;
    meter_clear = 1'b0;
    pix_en      = 1'b0;
    line_close  = 1'b0;
    report      = 1'b0;
    if (!enable_i) begin
      state_next = S_SYNC;
    end else begin
      case (state_reg)
        S_SYNC: begin
          if (vs_edge) begin
            meter_clear = 1'b1;
            pix_en      = de_i;
            state_next  = S_FRAME;
          end
        end
        S_FRAME: begin
          if (vs_edge) begin
            // Line ending or still open at the edge closes in the old frame.
            line_close  = de_q_reg;
            report      = 1'b1;
            meter_clear = 1'b1;
            pix_en      = de_i;
          end else begin
            line_close = line_end;
            pix_en     = de_i;
          end
        end
        default: state_next = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_SYNC;
      vs_q_reg  <= 1'b0;
      de_q_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      vs_q_reg  <= vs_act;
      de_q_reg  <= de_i;
    end
  end

  picture_line_meter #(
    .CounterWidthX(CounterWidthX),
    .CounterWidthY(CounterWidthY)
  ) u_line_meter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear       (meter_clear),
    .pix_en      (pix_en),
    .line_close  (line_close),
    .width_cur   (meter_width),
    .height_cur  (meter_height),
    .line_err_cur(meter_line_err),
    .ovf_cur     (meter_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_reg       <= '0;
      height_reg      <= '0;
      line_err_reg    <= 1'b0;
      ovf_err_reg     <= 1'b0;
      frame_valid_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      frame_valid_reg <= report;
      if (report) begin
        width_reg     <= meter_width;
        height_reg    <= meter_height;
        line_err_reg  <= meter_line_err;
        ovf_err_reg   <= meter_ovf;
        frame_cnt_reg <= frame_cnt_reg + FrameOne;
      end
    end
  end

`ifdef PICTURE_CHECK_CRC_EN
  logic [15:0] pix_word;
  logic [15:0] crc_seed;
  logic [15:0] crc_reg, crc_out_reg;

  assign pix_word = data_i;
  assign crc_seed = meter_clear ? Crc16Init : crc_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_reg     <= Crc16Init;
      crc_out_reg <= '0;
    end else begin
      if (pix_en) begin
        crc_reg <= crc16_ccitt_word(crc_seed, pix_word);
      end else if (meter_clear) begin
        crc_reg <= Crc16Init;
      end
      if (report) begin
        crc_out_reg <= crc_reg;
      end
    end
  end

  assign crc_o = crc_out_reg;
`else
  logic data_unused;
  assign data_unused = ^data_i;
  assign crc_o       = 16'h0000;
`endif

  assign width_o       = width_reg;
  assign height_o      = height_reg;
  assign line_err_o    = line_err_reg;
  assign ovf_err_o     = ovf_err_reg;
  assign frame_valid_o = frame_valid_reg;
  assign frame_cnt_o   = frame_cnt_reg;

endmodule
